bit_stuffer: RTL
================

// Module: bit_stuffer
// PURPOSE
//  USB transmit bit stuffer: sits directly downstream of the crc16 generator and packet serializer mux.
//  Consumes the serial packet stream (PID/addr/data, then CRC bits) one bit per cycle.
//  Emits the stuffed stream toward the NRZI encoder, inserting a 0 after every RUN_LEN consecutive 1s.
//  Stalls the upstream shifter for exactly one cycle per inserted bit.
// PARAMETERS
//  RUN_LEN  6                       consecutive 1s that force a stuffed 0
//  CNT_W    $clog2(RUN_LEN+1)       width of the ones-run counter (derived; do not override)
// PORTS
//  clk           in   1  system clock, all state on posedge
//  rst_n         in   1  asynchronous, active-low reset
//  bs_start      in   1  1-cycle pulse: begin a new packet (ignored unless IDLE)
//  s_in          in   1  serial packet bit from upstream
//  s_valid       in   1  s_in is valid and is consumed this cycle (unless bs_stall)
//  bs_end        in   1  qualifies s_in as the last packet bit (meaningful only with s_valid)
//  bs_out        out  1  stuffed serial bit (registered)
//  bs_out_valid  out  1  bs_out is valid this cycle (registered)
//  bs_stall      out  1  upstream must hold s_in / not advance this cycle
//  bs_busy       out  1  packet in progress (state != IDLE)
//  bs_done       out  1  1-cycle pulse once the final output bit, including any trailing stuff bit, has been emitted
// BEHAVIOUR
//  Clock and reset
//  - One clock domain. Reset is asynchronous and active-low.
//  - Reset (any time, including mid-packet or in STUFF) forces state IDLE and ones_cnt=0.
//  - Reset values: bs_out=0, bs_out_valid=0, bs_stall=0, bs_busy=0, bs_done=0.
//  States
//  - IDLE
//    - bs_start -> RUN, ones_cnt cleared.
//    - s_in on the start cycle is ignored; the first bit is accepted on the next cycle.
//    - s_valid and bs_end are ignored in IDLE.
//  - RUN, s_valid=1
//    - Register bs_out<=s_in, bs_out_valid<=1.
//    - ones_cnt <= s_in ? ones_cnt+1 : 0.
//    - If s_in=1 and ones_cnt==RUN_LEN-1: next state is TAIL when bs_end=1, else STUFF.
//    - Else if bs_end=1: next state DONE.
//  - RUN, s_valid=0 (gap)
//    - bs_out_valid<=0 and bs_out holds.
//    - ones_cnt is retained, so runs span gaps.
//  - STUFF
//    - bs_stall=1, decoded combinationally from the state register.
//    - s_in, s_valid and bs_end are ignored.
//    - Register bs_out<=0, bs_out_valid<=1, ones_cnt<=0, then -> RUN.
//  - TAIL: same output as STUFF (bs_stall=1, emit 0, clear count), then -> DONE.
//  - DONE: bs_done=1 and bs_out_valid<=0, then -> IDLE.
//  Timing
//  - Latency is one cycle: a bit accepted at cycle t appears on bs_out at t+1.
//  - The stuffed 0 appears at t+2 after the sixth 1 accepted at t; bs_stall is high during t+1.
//  - The ones run counts only source bits; a stuffed 0 resets the run.
//  - Consecutive runs stuff independently, e.g. 12 ones produce two stuffed 0s.
//  - bs_start while bs_busy=1 is ignored.
//  - bs_busy=1 in RUN, STUFF, TAIL and DONE.
// STRUCTURE
//  - usb_pkg holds:
//    - typedef enum logic [2:0] {BS_IDLE, BS_RUN, BS_STUFF, BS_TAIL, BS_DONE} bs_state_t
//    - localparam USB_STUFF_LEN = 6
//  - Sub-module: ones-run count uses the existing counter #(CNT_W).
//    - clr = rst of run (s_in=0 accepted, STUFF/TAIL, bs_start).
//    - en = accepted 1.
//  - FSM: separate always_ff state register and always_comb next-state/output decode.
//  - bs_out/bs_out_valid are output flops.
// TESTING
//  - In 11111111 with bs_end on bit 8, s_valid always 1.
//    -> Out valid bits 1,1,1,1,1,1,0,1,1.
//    -> bs_stall high 1 cycle after bit 6 accepted.
//    -> bs_done 1 cycle after last out.
//  - In 0x00 (8 zeros), bs_end on bit 8 -> 8 zeros out, bs_stall never high, bs_done once.
//  - Exactly six 1s with bs_end on the 6th -> TAIL emits trailing 0 (7 valid outs), then bs_done.
//  - 12 consecutive 1s -> out 111111 0 111111 0; two stall cycles; count restarts after each stuff.
//  - Ones 1-3, s_valid low 2 cycles, then ones 4-6 -> count retained across gap; stuff 0 after 6th.
//  - Assert rst_n low while in STUFF.
//    -> All outputs 0 and state IDLE.
//    -> Next bs_start and packet 0xFF produce 111111 0 11 correctly.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared definitions for the USB transmit path: bit-stuffer FSM states,
// the stuffing run length and small state-decode helpers.
package usb_pkg;

    // Bit-stuffer FSM states.
    typedef enum logic [2:0] {
        BS_IDLE  = 3'd0,
        BS_RUN   = 3'd1,
        BS_STUFF = 3'd2,
        BS_TAIL  = 3'd3,
        BS_DONE  = 3'd4
    } bs_state_t;

    // Number of consecutive 1s that force an inserted 0.
    localparam int USB_STUFF_LEN = 6;

    // True in the states that emit an inserted 0 and hold the upstream shifter.
    function automatic logic bs_is_stall_state(input bs_state_t st);
        return (st == BS_STUFF) || (st == BS_TAIL);
    endfunction

    // True whenever a packet is in progress.
    function automatic logic bs_is_busy_state(input bs_state_t st);
        return (st != BS_IDLE);
    endfunction

endpackage

// File: rtl/bit_stuffer_counter.sv
// Generic up-counter with synchronous clear (priority) and enable.
// Used by the bit stuffer to track the current run of source 1s.
module counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins over increment, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/bit_stuffer.sv
// USB transmit bit stuffer. Takes the serialized packet one bit per cycle
// and inserts a 0 after every RUN_LEN consecutive source 1s, stalling the
// upstream shifter for the one cycle in which the inserted bit is emitted.
// A run of 1s that ends exactly on the last packet bit still gets its
// trailing 0 (TAIL state) before completion is signalled.
module bit_stuffer
    import usb_pkg::*;
#(
    parameter int RUN_LEN = USB_STUFF_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bs_start,
    input  logic s_in,
    input  logic s_valid,
    input  logic bs_end,
    output logic bs_out,
    output logic bs_out_valid,
    output logic bs_stall,
    output logic bs_busy,
    output logic bs_done
);

    // Counter width follows from the run length; not meant to be overridden.
    localparam int CNT_W = $clog2(RUN_LEN + 1);

    bs_state_t        state_q;
    bs_state_t        state_d;
    logic             bs_out_q;
    logic             bs_out_d;
    logic             bs_out_valid_q;
    logic             bs_out_valid_d;
    logic             bs_done_q;
    logic             bs_done_d;
    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic             run_full_s;
    logic [CNT_W-1:0] ones_cnt_s;

    // Ones-run counter: cleared on a source 0, on every inserted 0 and at
    // packet start; incremented on every accepted source 1.
    counter #(
        .WIDTH (CNT_W)
    ) u_ones_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .cnt   (ones_cnt_s)
    );

    // The bit being accepted completes a run when RUN_LEN-1 ones precede it.
    assign run_full_s = (ones_cnt_s == CNT_W'(RUN_LEN - 1));

    // Next-state, counter control and output-flop decode.
    always_comb begin
        state_d        = state_q;
        bs_out_d       = bs_out_q;
        bs_out_valid_d = 1'b0;
        bs_done_d      = 1'b0;
        cnt_clr_s      = 1'b0;
        cnt_en_s       = 1'b0;
        case (state_q)
            BS_IDLE: begin
                // s_in/s_valid/bs_end are don't-care until the packet starts.
                if (bs_start) begin
                    state_d   = BS_RUN;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_d = BS_IDLE;
                end
            end
            BS_RUN: begin
                if (s_valid) begin
                    bs_out_d       = s_in;
                    bs_out_valid_d = 1'b1;
                    if (s_in) begin
                        cnt_en_s = 1'b1;
                        if (run_full_s) begin
                            state_d = bs_end ? BS_TAIL : BS_STUFF;
                        end else if (bs_end) begin
                            state_d = BS_DONE;
                        end else begin
                            state_d = BS_RUN;
                        end
                    end else begin
                        cnt_clr_s = 1'b1;
                        state_d   = bs_end ? BS_DONE : BS_RUN;
                    end
                end else begin
                    // Gap: count is kept so a run can span idle cycles.
                    state_d = BS_RUN;
                end
            end
            BS_STUFF: begin
                bs_out_d       = 1'b0;
                bs_out_valid_d = 1'b1;
                cnt_clr_s      = 1'b1;
                state_d        = BS_RUN;
            end
            BS_TAIL: begin
                bs_out_d       = 1'b0;
                bs_out_valid_d = 1'b1;
                cnt_clr_s      = 1'b1;
                state_d        = BS_DONE;
            end
            BS_DONE: begin
                // Last output bit is on the wire this cycle; done follows it.
                bs_done_d = 1'b1;
                state_d   = BS_IDLE;
            end
            default: begin
                cnt_clr_s = 1'b1;
                state_d   = BS_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered serial output, its valid flag and the completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bs_out_q       <= 1'b0;
            bs_out_valid_q <= 1'b0;
            bs_done_q      <= 1'b0;
        end else begin
            bs_out_q       <= bs_out_d;
            bs_out_valid_q <= bs_out_valid_d;
            bs_done_q      <= bs_done_d;
        end
    end

    assign bs_out       = bs_out_q;
    assign bs_out_valid = bs_out_valid_q;
    assign bs_done      = bs_done_q;
    assign bs_stall     = bs_is_stall_state(state_q);
    assign bs_busy      = bs_is_busy_state(state_q);

endmodule
